// File: rtl/i2c_txn_seq_if.sv
// i2c_txn_seq_if: requester, response and engine bundle for i2c_txn_seq.
// master = sequencer view; slave = requesters + byte engine view.
interface i2c_txn_seq_if #(
  parameter int MAX_BYTES = 4
);
  localparam int DW = 8 * MAX_BYTES;

  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic          req0_rw, req1_rw;
  logic [6:0]    req0_addr, req1_addr;
  logic [7:0]    req0_index, req1_index;
  logic [1:0]    req0_len, req1_len;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          eng_cmd_valid, eng_cmd_ready;
  logic [2:0]    eng_cmd;
  logic [7:0]    eng_wbyte;
  logic          eng_mnack;
  logic          eng_rsp_valid;
  logic [7:0]    eng_rbyte;
  logic          eng_sack;

  modport master (
    input  req0_valid, req1_valid, req0_rw, req1_rw,
    input  req0_addr, req1_addr, req0_index, req1_index,
    input  req0_len, req1_len, req0_wdata, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_err, rsp_rdata,
    output eng_cmd_valid, eng_cmd, eng_wbyte, eng_mnack,
    input  eng_cmd_ready, eng_rsp_valid, eng_rbyte, eng_sack
  );

  modport slave (
    output req0_valid, req1_valid, req0_rw, req1_rw,
    output req0_addr, req1_addr, req0_index, req1_index,
    output req0_len, req1_len, req0_wdata, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_err, rsp_rdata,
    input  eng_cmd_valid, eng_cmd, eng_wbyte, eng_mnack,
    output eng_cmd_ready, eng_rsp_valid, eng_rbyte, eng_sack
  );
endinterface

// File: rtl/i2c_txn_seq.sv
// i2c_txn_seq: round-robin I2C register transaction sequencer.
// Ports: CLK, RST (sync, active high), bus (i2c_txn_seq_if.master).
module i2c_txn_seq #(
  parameter int MAX_BYTES = 4
) (
  input logic           CLK,
  input logic           RST,
  i2c_txn_seq_if.master bus
);
  localparam int DW = 8 * MAX_BYTES;
  localparam logic [2:0] C_START   = 3'd0;
  localparam logic [2:0] C_RESTART = 3'd1;
  localparam logic [2:0] C_WRITE   = 3'd2;
  localparam logic [2:0] C_READ    = 3'd3;
  localparam logic [2:0] C_STOP    = 3'd4;

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, INDEX, WDATA,
    RESTART, ADDR_R, RDATA, STOP, DONE
  } st_t;
  typedef enum logic [1:0] {
    PH_LOAD, PH_ISSUE, PH_WAIT
  } ph_t;

  st_t           st_q, st_d, tgt;
  ph_t           ph_q;
  // owner of the current transaction; also the RR pointer
  logic          own_q;
  logic          rw_q;
  logic [6:0]    addr_q;
  logic [7:0]    idx_q;
  logic [1:0]    len_q, cnt_q, cnt_d, tcnt;
  logic [DW-1:0] wdata_q, rdata_q;
  logic          err_q;
  logic          rdy0_q, rdy1_q, rsp0_q, rsp1_q;
  logic          cv_q, mn_q, mn_n;
  logic [2:0]    cmd_q, cmd_n;
  logic [7:0]    wb_q, wb_n;
  logic          nack, any_req, pick1;

  assign any_req = bus.req0_valid | bus.req1_valid;
  assign pick1   = bus.req1_valid & (~bus.req0_valid | ~own_q);
  assign nack    = bus.eng_sack &
                   (st_q inside {ADDR_W, INDEX, WDATA, ADDR_R});

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      START:   st_d = ADDR_W;
      ADDR_W:  st_d = INDEX;
      INDEX: begin
        st_d  = rw_q ? RESTART : WDATA;
        cnt_d = '0;
      end
      RESTART: st_d = ADDR_R;
      ADDR_R: begin
        st_d  = RDATA;
        cnt_d = '0;
      end
      WDATA, RDATA: begin
        if (cnt_q == len_q) st_d = STOP;
        else cnt_d = cnt_q + 2'd1;
      end
      STOP:    st_d = DONE;
      default: st_d = st_q;
    endcase
    if (nack) st_d = STOP;
  end

  // The next command is built for the state being entered so it
  // can be presented the cycle right after eng_rsp_valid.
  assign tgt  = (ph_q == PH_LOAD) ? st_q : st_d;
  assign tcnt = (ph_q == PH_LOAD) ? cnt_q : cnt_d;

  always_comb begin
    cmd_n = C_START;
    wb_n  = '0;
    mn_n  = 1'b0;
    unique case (tgt)
      RESTART: cmd_n = C_RESTART;
      ADDR_W: begin
        cmd_n = C_WRITE;
        wb_n  = {addr_q, 1'b0};
      end
      INDEX: begin
        cmd_n = C_WRITE;
        wb_n  = idx_q;
      end
      WDATA: begin
        cmd_n = C_WRITE;
        wb_n  = wdata_q[{tcnt, 3'b000} +: 8];
      end
      ADDR_R: begin
        cmd_n = C_WRITE;
        wb_n  = {addr_q, 1'b1};
      end
      RDATA: begin
        cmd_n = C_READ;
        mn_n  = (tcnt == len_q);
      end
      STOP:    cmd_n = C_STOP;
      default: cmd_n = C_START;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= IDLE;
      ph_q    <= PH_LOAD;
      own_q   <= 1'b1;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      cv_q    <= 1'b0;
      cmd_q   <= '0;
      wb_q    <= '0;
      mn_q    <= 1'b0;
    end else begin
      rdy0_q <= 1'b0;
      rdy1_q <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      if (st_q == IDLE || st_q == DONE) begin
        st_q <= IDLE;
        if (any_req) begin
          st_q    <= START;
          ph_q    <= PH_LOAD;
          own_q   <= pick1;
          rdy0_q  <= ~pick1;
          rdy1_q  <= pick1;
          cnt_q   <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
      end else begin
        unique case (ph_q)
          PH_LOAD: begin
            // fields sampled at the end of the ready cycle
            rw_q    <= own_q ? bus.req1_rw    : bus.req0_rw;
            addr_q  <= own_q ? bus.req1_addr  : bus.req0_addr;
            idx_q   <= own_q ? bus.req1_index : bus.req0_index;
            len_q   <= own_q ? bus.req1_len   : bus.req0_len;
            wdata_q <= own_q ? bus.req1_wdata : bus.req0_wdata;
            cv_q    <= 1'b1;
            cmd_q   <= cmd_n;
            wb_q    <= wb_n;
            mn_q    <= mn_n;
            ph_q    <= PH_ISSUE;
          end
          PH_ISSUE: begin
            if (bus.eng_cmd_ready) begin
              cv_q <= 1'b0;
              ph_q <= PH_WAIT;
            end
          end
          PH_WAIT: begin
            if (bus.eng_rsp_valid) begin
              if (nack) err_q <= 1'b1;
              if (st_q == RDATA)
                rdata_q[{cnt_q, 3'b000} +: 8] <= bus.eng_rbyte;
              st_q  <= st_d;
              cnt_q <= cnt_d;
              if (st_d == DONE) begin
                rsp0_q <= ~own_q;
                rsp1_q <= own_q;
              end else begin
                cv_q  <= 1'b1;
                cmd_q <= cmd_n;
                wb_q  <= wb_n;
                mn_q  <= mn_n;
                ph_q  <= PH_ISSUE;
              end
            end
          end
          default: ph_q <= PH_LOAD;
        endcase
      end
    end
  end

  assign bus.req0_ready    = rdy0_q;
  assign bus.req1_ready    = rdy1_q;
  assign bus.rsp0_valid    = rsp0_q;
  assign bus.rsp1_valid    = rsp1_q;
  assign bus.rsp_err       = err_q;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.eng_cmd_valid = cv_q;
  assign bus.eng_cmd       = cmd_q;
  assign bus.eng_wbyte     = wb_q;
  assign bus.eng_mnack     = mn_q;
endmodule

// File: tb/tb_i2c_txn_seq.sv
// tb_i2c_txn_seq: scoreboard bench for i2c_txn_seq.
// Engine model + requester tasks; expected cmds/rsps queued at issue.
module tb_i2c_txn_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_txn_seq_if bus ();
  i2c_txn_seq dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } rsp_t;

  logic [11:0] exp_cmd[$];
  rsp_t        exp_rsp[$];
  logic        exp_gnt[$];
  logic [7:0]  rd_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int nack_at = -1;
  int stall_at = -1;
  int stall_len = 0;
  int stall_left = 0;
  int cmd_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {bus.req0_ready, bus.req1_ready,
        bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err,
        bus.eng_cmd_valid, bus.eng_cmd, bus.eng_wbyte,
        bus.eng_mnack}, 0);
    chk({tag, "_rdata"}, bus.rsp_rdata, 0);
  endtask

  // engine model: decides ready at negedge, answers one cycle later
  initial begin : engine
    logic        acc;
    int          acc_no;
    logic [11:0] acc_cmd, cur, snap;
    bus.eng_cmd_ready = 1'b0;
    bus.eng_rsp_valid = 1'b0;
    bus.eng_rbyte = 8'h00;
    bus.eng_sack = 1'b0;
    acc = 1'b0;
    acc_no = 0;
    acc_cmd = '0;
    snap = '0;
    forever begin
      @(negedge clk);
      bus.eng_rsp_valid = 1'b0;
      bus.eng_sack = 1'b0;
      bus.eng_rbyte = 8'h00;
      if (rst) begin
        acc = 1'b0;
        bus.eng_cmd_ready = 1'b0;
      end else begin
        if (acc) begin
          bus.eng_rsp_valid = 1'b1;
          if (acc_cmd[11:9] == 3'd3 && rd_q.size() != 0)
            bus.eng_rbyte = rd_q.pop_front();
          if (acc_cmd[11:9] == 3'd2 && acc_no == nack_at)
            bus.eng_sack = 1'b1;
        end
        acc = 1'b0;
        bus.eng_cmd_ready = 1'b0;
        if (bus.eng_cmd_valid) begin
          cur = {bus.eng_cmd,
                 (bus.eng_cmd == 3'd2) ? bus.eng_wbyte : 8'h00,
                 (bus.eng_cmd == 3'd3) ? bus.eng_mnack : 1'b0};
          if (cur[11:9] == 3'd0) cmd_no = 0;
          if (cmd_no == stall_at && stall_left > 0) begin
            if (stall_left == stall_len) snap = cur;
            else chk("cmd_hold", cur, snap);
            stall_left--;
          end else begin
            bus.eng_cmd_ready = 1'b1;
            acc = 1'b1;
            acc_cmd = cur;
            acc_no = cmd_no;
            chk("cmd_pending", exp_cmd.size() != 0, 1);
            if (exp_cmd.size() != 0)
              chk($sformatf("cmd%0d", cmd_no), cur,
                  exp_cmd.pop_front());
            cmd_no++;
          end
        end
      end
    end
  end

  // grant and response monitor
  initial begin : mon
    rsp_t r;
    int   gcyc;
    gcyc = 0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.req0_ready || bus.req1_ready)) begin
        gcyc = cyc;
        chk("gnt_pending", exp_gnt.size() != 0, 1);
        if (exp_gnt.size() != 0)
          chk("gnt_who", {bus.req1_ready, bus.req0_ready},
              exp_gnt.pop_front() ? 2'b10 : 2'b01);
      end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        chk("rsp_pending", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          r = exp_rsp.pop_front();
          chk("rsp_who", {bus.rsp1_valid, bus.rsp0_valid},
              r.id ? 2'b10 : 2'b01);
          chk("rsp_err", bus.rsp_err, r.err);
          chk("rsp_rdata", bus.rsp_rdata, r.rdata);
          chk("rsp_lat", cyc - gcyc, r.lat);
        end
      end
    end
  end

  // reference model of one transaction's command stream and result
  task automatic expect_txn(input logic id, input logic rw,
                            input logic [6:0] a, input logic [7:0] ix,
                            input logic [1:0] len,
                            input logic [31:0] wd,
                            input logic [31:0] rd,
                            input int nk, input int stall);
    int   n;
    logic err;
    rsp_t r;
    err = 1'b0;
    r.rdata = '0;
    exp_gnt.push_back(id);
    exp_cmd.push_back({3'd0, 8'h00, 1'b0});
    n = 1;
    exp_cmd.push_back({3'd2, a, 1'b0, 1'b0});
    if (nk == n) err = 1'b1;
    n++;
    if (!err) begin
      exp_cmd.push_back({3'd2, ix, 1'b0});
      if (nk == n) err = 1'b1;
      n++;
    end
    if (!err && !rw) begin
      for (int k = 0; k <= int'(len); k++) begin
        if (!err) begin
          exp_cmd.push_back({3'd2, wd[8*k +: 8], 1'b0});
          if (nk == n) err = 1'b1;
          n++;
        end
      end
    end
    if (!err && rw) begin
      exp_cmd.push_back({3'd1, 8'h00, 1'b0});
      n++;
      exp_cmd.push_back({3'd2, a, 1'b1, 1'b0});
      if (nk == n) err = 1'b1;
      n++;
      if (!err) begin
        for (int k = 0; k <= int'(len); k++) begin
          exp_cmd.push_back({3'd3, 8'h00, k == int'(len)});
          rd_q.push_back(rd[8*k +: 8]);
          r.rdata[8*k +: 8] = rd[8*k +: 8];
          n++;
        end
      end
    end
    exp_cmd.push_back({3'd4, 8'h00, 1'b0});
    n++;
    r.id = id;
    r.err = err;
    r.lat = 2 * n + 1 + stall;
    exp_rsp.push_back(r);
  endtask

  task automatic send(input logic id, input logic rw,
                      input logic [6:0] a, input logic [7:0] ix,
                      input logic [1:0] len, input logic [31:0] wd);
    int t;
    if (id) begin
      bus.req1_rw = rw; bus.req1_addr = a; bus.req1_index = ix;
      bus.req1_len = len; bus.req1_wdata = wd; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_rw = rw; bus.req0_addr = a; bus.req0_index = ix;
      bus.req0_len = len; bus.req0_wdata = wd; bus.req0_valid = 1'b1;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(id ? bus.req1_ready : bus.req0_ready) && t < 200);
    chk("req_granted", id ? bus.req1_ready : bus.req0_ready, 1);
    if (id) bus.req1_valid = 1'b0;
    else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_rsp.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_outstanding", exp_rsp.size(), 0);
    chk("cmd_outstanding", exp_cmd.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic id, input logic rw,
                     input logic [6:0] a, input logic [7:0] ix,
                     input logic [1:0] len, input logic [31:0] wd,
                     input logic [31:0] rd, input int nk,
                     input int stall);
    nack_at = nk;
    expect_txn(id, rw, a, ix, len, wd, rd, nk, stall);
    send(id, rw, a, ix, len, wd);
    wait_done();
    nack_at = -1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    // both requesters held continuously from reset
    bus.req0_rw = 1'b0; bus.req0_addr = 7'h55; bus.req0_index = 8'h00;
    bus.req0_len = 2'd0; bus.req0_wdata = 32'h11; bus.req0_valid = 1'b1;
    bus.req1_rw = 1'b0; bus.req1_addr = 7'h55; bus.req1_index = 8'h02;
    bus.req1_len = 2'd0; bus.req1_wdata = 32'h22; bus.req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        expect_txn(1'b0, 1'b0, 7'h55, 8'h00, 2'd0, 32'h11, 0, -1, 0);
      else
        expect_txn(1'b1, 1'b0, 7'h55, 8'h02, 2'd0, 32'h22, 0, -1, 0);
    end
    rst = 1'b0;
    t = 0;
    while (exp_gnt.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("arb_grants", exp_gnt.size(), 0);
    wait_done();

    // single-byte write
    run(1'b0, 1'b0, 7'h55, 8'h01, 2'd0, 32'h5A, 0, -1, 0);
    // two-byte read
    run(1'b1, 1'b1, 7'h55, 8'h01, 2'd1, 0, 32'h0000AA5A, -1, 0);
    // single-byte read
    run(1'b0, 1'b1, 7'h55, 8'h03, 2'd0, 0, 32'h3C, -1, 0);
    // address NACK
    run(1'b0, 1'b0, 7'h55, 8'h01, 2'd0, 32'h5A, 0, 1, 0);
    // NACK on second data byte of a 3-byte write
    run(1'b1, 1'b0, 7'h55, 8'h00, 2'd2, 32'h00332211, 0, 4, 0);
    // NACK on read address after restart
    run(1'b0, 1'b1, 7'h55, 8'h00, 2'd3, 0, 32'h44332211, 4, 0);
    // four-byte read
    run(1'b1, 1'b1, 7'h55, 8'h00, 2'd3, 0, 32'hC3B2A190, -1, 0);

    // backpressure on INDEX
    stall_at = 2;
    stall_len = 3;
    stall_left = 3;
    run(1'b1, 1'b0, 7'h55, 8'h00, 2'd3, 32'hDDCCBBAA, 0, -1, 3);
    chk("stall_used", stall_left, 0);
    stall_at = -1;

    // reset in the middle of a 4-byte write
    expect_txn(1'b0, 1'b0, 7'h55, 8'h00, 2'd3, 32'h87654321, 0, -1, 0);
    send(1'b0, 1'b0, 7'h55, 8'h00, 2'd3, 32'h87654321);
    t = 0;
    while (cmd_no < 5 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("mid_wdata", cmd_no >= 5, 1);
    #1;
    rst = 1'b1;
    exp_cmd.delete();
    exp_rsp.delete();
    exp_gnt.delete();
    rd_q.delete();
    @(negedge clk);
    chk_reset("midrst");
    #1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_quiet", exp_cmd.size(), 0);
    run(1'b0, 1'b0, 7'h55, 8'h02, 2'd1, 32'h3344, 0, -1, 0);
    run(1'b1, 1'b1, 7'h55, 8'h02, 2'd1, 0, 32'h3344, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
